// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default geometry.
// Used by both the read-side and write-side pointer controllers.
package fifo_rd_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 3;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
    localparam int unsigned GRAY_MAX_WIDTH        = 32;

    // Callers zero-extend into GRAY_MAX_WIDTH and size-cast the result back.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clock domains.
// The first flop samples the asynchronous input directly; no logic in front of it.
module ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: W_PTR synchronisation, read pointer/address,
// EMPTY and fill level, plus a one-word first-word-fall-through output register.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic                     R_CLK,
    input  logic                     R_RST,
    input  logic [ADDRESS_WIDTH:0]   W_PTR,
    input  logic [DATA_WIDTH-1:0]    RD_DATA,
    output logic [ADDRESS_WIDTH-1:0] R_ADDR,
    output logic [ADDRESS_WIDTH:0]   R_PTR,
    output logic                     EMPTY,
    output logic [DATA_WIDTH-1:0]    OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [ADDRESS_WIDTH:0]   FILL_LEVEL
);

    localparam int unsigned PW = ADDRESS_WIDTH + 1;

    logic [PW-1:0]         wq;
    logic [PW-1:0]         wq_bin;
    logic [PW-1:0]         r_bin_q;
    logic [PW-1:0]         r_bin_d;
    logic [PW-1:0]         r_ptr_q;
    logic [PW-1:0]         r_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  pop;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_w_ptr_sync (
        .clk   (R_CLK),
        .rst_n (R_RST),
        .d     (W_PTR),
        .q     (wq)
    );

    // Full-width compare: the extra MSB separates "empty" from "full".
    assign EMPTY = (r_ptr_q == wq);
    assign pop   = !EMPTY && (!out_valid_q || OUT_READY);

    always_comb begin
        r_bin_d     = r_bin_q + PW'(pop);
        // Gray pointer is registered from the next binary value so it never lags R_BIN.
        r_ptr_d     = PW'(bin2gray(GRAY_MAX_WIDTH'(r_bin_d)));
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            out_data_d  = RD_DATA;
            out_valid_d = 1'b1;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            r_bin_q     <= '0;
            r_ptr_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            r_bin_q     <= r_bin_d;
            r_ptr_q     <= r_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign wq_bin     = PW'(gray2bin(GRAY_MAX_WIDTH'(wq)));
    assign FILL_LEVEL = wq_bin - r_bin_q;
    assign R_ADDR     = r_bin_q[ADDRESS_WIDTH-1:0];
    assign R_PTR      = r_ptr_q;
    assign OUT_DATA   = out_data_q;
    assign OUT_VALID  = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl against a word-count reference model.
module tb_fifo_rd_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b0;
    logic [3:0] w_ptr = '0;
    logic [7:0] rd_data;
    logic [2:0] r_addr;
    logic [3:0] r_ptr;
    logic       empty;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] fill_level;

    logic [7:0] mem [8];
    logic [7:0] words [1024];

    // Reference model state, in plain word counts.
    int         wr_total;
    int         rd_total;
    int         pipe0;
    int         pipe1;
    logic       m_valid;
    logic [7:0] m_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 r_clk = ~r_clk;

    assign rd_data = mem[r_addr];

    fifo_rd_ctrl #(
        .ADDRESS_WIDTH (3),
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2)
    ) dut (
        .R_CLK      (r_clk),
        .R_RST      (r_rst),
        .W_PTR      (w_ptr),
        .RD_DATA    (rd_data),
        .R_ADDR     (r_addr),
        .R_PTR      (r_ptr),
        .EMPTY      (empty),
        .OUT_DATA   (out_data),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .FILL_LEVEL (fill_level)
    );

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("empty", 32'(empty), 32'(pipe1 == rd_total));
        check_eq("fill_level", 32'(fill_level), 32'(pipe1 - rd_total));
        check_eq("r_addr", 32'(r_addr), 32'(rd_total % 8));
        check_eq("r_ptr", 32'(r_ptr), 32'(to_gray(rd_total)));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), 32'(m_data));
    endtask

    task automatic model_reset();
        rd_total = 0;
        pipe0    = 0;
        pipe1    = 0;
        m_valid  = 1'b0;
        m_data   = '0;
    endtask

    // One R_CLK edge: advance the model with the pre-edge inputs, then compare.
    task automatic step();
        bit pop;
        pop = (pipe1 != rd_total) && (!m_valid || out_ready);
        @(posedge r_clk);
        #1;
        if (pop) begin
            m_data  = words[rd_total % 1024];
            m_valid = 1'b1;
            rd_total++;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        pipe1 = pipe0;
        pipe0 = wr_total;
        check_model();
    endtask

    task automatic write_word(input logic [7:0] data);
        words[wr_total % 1024] = data;
        mem[wr_total % 8]      = data;
        wr_total++;
        w_ptr = to_gray(wr_total);
    endtask

    // Reset both domains; the writer comes out of reset with n words already written.
    task automatic reset_with(input int n, input logic ready);
        r_rst = 1'b0;
        wr_total = 0;
        for (int i = 0; i < n; i++) begin
            write_word(8'($urandom));
        end
        out_ready = ready;
        model_reset();
        #1;
        check_model();
        repeat (2) begin
            @(posedge r_clk);
            #1;
            check_model();
        end
        r_rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        wr_total = 0;
        model_reset();

        // Reset held with six words pending in the writer.
        reset_with(6, 1'b0);
        step();
        step();
        check_eq("rst_fill6", 32'(fill_level), 32'd6);
        check_eq("rst_not_empty", 32'(empty), 32'd0);
        repeat (3) step();
        out_ready = 1'b1;
        repeat (8) step();

        // Single word through the pipeline.
        reset_with(0, 1'b1);
        mem[0]   = 8'hA5;
        words[0] = 8'hA5;
        wr_total = 1;
        w_ptr    = 4'b0001;
        step();
        step();
        check_eq("sw_e2_empty", 32'(empty), 32'd0);
        check_eq("sw_e2_fill", 32'(fill_level), 32'd1);
        step();
        check_eq("sw_e3_valid", 32'(out_valid), 32'd1);
        check_eq("sw_e3_data", 32'(out_data), 32'hA5);
        check_eq("sw_e3_addr", 32'(r_addr), 32'd1);
        check_eq("sw_e3_ptr", 32'(r_ptr), 32'b0001);
        check_eq("sw_e3_empty", 32'(empty), 32'd1);
        step();
        check_eq("sw_e4_valid", 32'(out_valid), 32'd0);

        // Backpressure with three pending words, then release.
        out_ready = 1'b0;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        repeat (6) step();
        check_eq("bp_fill", 32'(fill_level), 32'd2);
        check_eq("bp_addr", 32'(r_addr), 32'd2);
        check_eq("bp_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        repeat (4) step();

        // Continuous reading while the writer wraps the pointers several times.
        for (int c = 0; c < 120; c++) begin
            if ((wr_total - rd_total) < 8 && $urandom_range(9) < 7) write_word(8'($urandom));
            step();
        end
        // Random backpressure and write gaps.
        for (int c = 0; c < 300; c++) begin
            if ((wr_total - rd_total) < 8 && $urandom_range(9) < 6) write_word(8'($urandom));
            out_ready = 1'($urandom_range(1));
            step();
        end

        // Full memory: eight words visible, drained back-to-back.
        reset_with(8, 1'b1);
        step();
        step();
        check_eq("full_fill8", 32'(fill_level), 32'd8);
        repeat (8) step();
        check_eq("full_empty", 32'(empty), 32'd1);
        check_eq("full_r_ptr", 32'(r_ptr), 32'b1100);
        check_eq("full_valid", 32'(out_valid), 32'd1);
        step();

        // Asynchronous reset while a word is held and three remain.
        reset_with(4, 1'b0);
        repeat (3) step();
        check_eq("mid_valid", 32'(out_valid), 32'd1);
        check_eq("mid_fill3", 32'(fill_level), 32'd3);
        #2;
        r_rst = 1'b0;
        #1;
        check_eq("async_valid", 32'(out_valid), 32'd0);
        check_eq("async_r_ptr", 32'(r_ptr), 32'd0);
        check_eq("async_fill", 32'(fill_level), 32'd0);
        check_eq("async_empty", 32'(empty), 32'd1);
        wr_total = 0;
        w_ptr    = '0;
        model_reset();
        #1;
        r_rst = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the async FIFO, paired with the write-side controller that produces the Gray write pointer. It synchronises the write pointer into the read domain, generates the binary read address and the Gray read pointer, and flags EMPTY. It also presents data through a one-word first-word-fall-through output register with a valid/ready handshake. It sits between the dual-port FIFO memory and the read-domain consumer, for example the UART TX path.

Parameters:
ADDRESS_WIDTH, 3, memory address bits; depth = 2^ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits
DATA_WIDTH, 8, width of the memory read data and OUT_DATA
SYNC_STAGES, 2, flops in the W_PTR synchroniser chain (minimum 2)

Ports:
R_CLK  in  1  read-domain clock
R_RST  in  1  asynchronous active-low reset
W_PTR  in  ADDRESS_WIDTH+1  Gray write pointer from the write domain (asynchronous)
RD_DATA  in  DATA_WIDTH  memory read data; combinational from R_ADDR
R_ADDR  out  ADDRESS_WIDTH  memory read address
R_PTR  out  ADDRESS_WIDTH+1  registered Gray read pointer, sent to the write domain
EMPTY  out  1  no unread word in memory (excludes the output register)
OUT_DATA  out  DATA_WIDTH  FWFT output word
OUT_VALID  out  1  OUT_DATA holds a valid word
OUT_READY  in  1  consumer accepts OUT_DATA this edge
FILL_LEVEL  out  ADDRESS_WIDTH+1  words in memory as seen by the read domain, 0..2^ADDRESS_WIDTH

Behaviour:
- Reset values (asynchronous, R_RST=0): binary counter R_BIN=0, R_PTR=0, all synchroniser flops=0, OUT_VALID=0, OUT_DATA=0. This gives EMPTY=1 and FILL_LEVEL=0.
- Synchronisation: W_PTR passes through SYNC_STAGES flops to give WQ. No logic sits in front of the first flop.
- EMPTY = (R_PTR == WQ). It is combinational from registers only.
- R_ADDR = R_BIN[ADDRESS_WIDTH-1:0].
- R_PTR is registered from the next binary value: R_PTR <= next_bin ^ (next_bin >> 1). R_PTR therefore always equals gray(R_BIN), with no one-cycle lag.
- Pop condition: pop = !EMPTY && (!OUT_VALID || OUT_READY).
- On pop: OUT_DATA <= RD_DATA, OUT_VALID <= 1, R_BIN <= R_BIN+1 (modulo 2^(ADDRESS_WIDTH+1)).
- When no pop occurs but OUT_VALID && OUT_READY: OUT_VALID <= 0. OUT_DATA holds its value.
- Simultaneous accept and pop: the word is replaced in the same edge and OUT_VALID stays 1. This sustains one word per cycle.
- OUT_DATA and OUT_VALID never change while OUT_VALID=1 && OUT_READY=0.
- Wrap-around: R_ADDR wraps from 2^ADDRESS_WIDTH-1 to 0. The pointer MSB toggles, and the EMPTY compare uses the full ADDRESS_WIDTH+1 bits.
- FILL_LEVEL = gray2bin(WQ) - R_BIN, modulo 2^(ADDRESS_WIDTH+1).
  - It is pessimistic: it lags writes by the synchroniser latency.
  - It equals 2^ADDRESS_WIDTH when the memory is full.
- Latency: a W_PTR change becomes visible in WQ after SYNC_STAGES R_CLK edges. EMPTY deasserts then, and OUT_VALID rises on the next edge. Total is SYNC_STAGES+1 edges.
- Reset mid-operation: everything clears immediately, and any word held in the output register is discarded. The write domain must be reset in the same system reset event.
- W_PTR must change by at most one Gray step per R_CLK-sampled transition. This is guaranteed by the writer's Gray coding.

Decomposition:
- Shared async-FIFO package/include:
  - bin2gray and gray2bin functions
  - default ADDRESS_WIDTH and SYNC_STAGES constants
  - these are reused by the write-side controller
- One sub-module: ptr_sync (parameters WIDTH and STAGES, asynchronous active-low reset, a flop chain per bit). It is instantiated here for W_PTR and reused in the write domain for R_PTR.

Test Plan:
- Reset: hold R_RST=0 with W_PTR=0101 → EMPTY=1, OUT_VALID=0, R_PTR=0000, R_ADDR=0, FILL_LEVEL=0. Release R_RST → FILL_LEVEL=6 and EMPTY=0 after 2 edges.
- Single word: W_PTR 0000→0001, RD_DATA@0=0xA5, OUT_READY=1 →
  - edge 2: EMPTY=0, FILL_LEVEL=1
  - edge 3: OUT_VALID=1, OUT_DATA=0xA5, R_ADDR=1, R_PTR=0001, EMPTY=1
  - edge 4: OUT_VALID=0
- Backpressure: OUT_READY=0, W_PTR=0010 (3 words) → one pop, then OUT_DATA is held. FILL_LEVEL=2 and R_ADDR=1 stay stable. Raising OUT_READY streams words 1 and 2 on consecutive edges.
- Wrap: the writer advances W_PTR through all 16 Gray codes while reading continuously →
  - R_PTR sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,...
  - R_ADDR wraps 7→0
  - no false EMPTY deassertion and no data mismatch against the reference model
- Full depth: R at 0, W_PTR=1100 (binary 8) → FILL_LEVEL=8, then 8 back-to-back pops with OUT_READY=1, ending with EMPTY=1 and R_PTR=1100.
- Mid-stream reset: assert R_RST while OUT_VALID=1 and FILL_LEVEL=3 → OUT_VALID, R_PTR and FILL_LEVEL go to 0 asynchronously, without waiting for an edge.
